// File: rtl/load_unit.sv
// load_unit: one-deep load stage between the load buffer and the ROB/CDB.
// It accepts a load, reads the data BRAM with a fixed latency, then aligns
// and extends the returned word. The result is held on a valid/ready port
// until it is accepted. Flush squashes the load that is in flight.
// Optional feature: define MISALIGN_CHECK_EN to add res_misalign_out.
module load_unit #(
    parameter int unsigned ROB_IX      = 2,
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned MEM_LATENCY = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              flush_in,
    input  logic              lb_valid_in,
    input  logic [31:0]       lb_addr_in,
    input  logic [ROB_IX:0]   lb_rob_ix_in,
    input  logic [2:0]        lb_funct3_in,
    output logic              read_out,
    output logic              mem_en_out,
    output logic [ADDR_W-1:0] mem_addr_out,
    input  logic [31:0]       mem_rdata_in,
    output logic              res_valid_out,
    input  logic              res_ready_in,
    output logic [31:0]       res_data_out,
`ifdef MISALIGN_CHECK_EN
    output logic              res_misalign_out,
`endif
    output logic [ROB_IX:0]   res_rob_ix_out
);

    localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        off_q, off_d;
    logic [2:0]        f3_q, f3_d;
    logic [ROB_IX:0]   rob_q, rob_d;
    logic              valid_q, valid_d;
    logic [31:0]       data_q, data_d;
`ifdef MISALIGN_CHECK_EN
    logic              mis_q, mis_d;
`endif
    logic              accept_c;
    logic              unused_addr;

    // Align and extend a returned BRAM word according to load type and byte offset.
    function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [2:0] f3,
                                             input logic [1:0] off);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  fmt_load = {{24{b[7]}}, b};
            3'b100:  fmt_load = {24'd0, b};
            3'b001:  fmt_load = {{16{h[15]}}, h};
            3'b101:  fmt_load = {16'd0, h};
            default: fmt_load = w;
        endcase
    endfunction

`ifdef MISALIGN_CHECK_EN
    // Halfwords need an even offset; words (and unknown types, treated as words) need offset 0.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000, 3'b100: is_misaligned = 1'b0;
            3'b001, 3'b101: is_misaligned = off[0];
            default:        is_misaligned = (off != 2'b00);
        endcase
    endfunction
`endif

    // Accept only when idle, not flushing and out of reset; the BRAM read fires in the same cycle.
    assign accept_c     = rst_in && (state_q == S_IDLE) && lb_valid_in && !flush_in;
    assign read_out     = accept_c;
    assign mem_en_out   = accept_c;
    assign mem_addr_out = lb_addr_in[ADDR_W+1:2];
    assign unused_addr  = ^{lb_addr_in[31:ADDR_W+2]};

    // Next-state and datapath: defaults hold, flush overrides everything.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        off_d   = off_q;
        f3_d    = f3_q;
        rob_d   = rob_q;
        valid_d = valid_q;
        data_d  = data_q;
`ifdef MISALIGN_CHECK_EN
        mis_d   = mis_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    off_d   = lb_addr_in[1:0];
                    f3_d    = lb_funct3_in;
                    rob_d   = lb_rob_ix_in;
                    cnt_d   = CNT_W'(MEM_LATENCY - 1);
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    data_d  = fmt_load(mem_rdata_in, f3_q, off_q);
`ifdef MISALIGN_CHECK_EN
                    mis_d   = is_misaligned(f3_q, off_q);
`endif
                    valid_d = 1'b1;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (res_ready_in) begin
                    valid_d = 1'b0;
`ifdef MISALIGN_CHECK_EN
                    mis_d   = 1'b0;
`endif
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (flush_in) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
`ifdef MISALIGN_CHECK_EN
            mis_d   = 1'b0;
`endif
        end
    end

    // State and result registers with asynchronous active-low reset.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            off_q   <= '0;
            f3_q    <= '0;
            rob_q   <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
`ifdef MISALIGN_CHECK_EN
            mis_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            off_q   <= off_d;
            f3_q    <= f3_d;
            rob_q   <= rob_d;
            valid_q <= valid_d;
            data_q  <= data_d;
`ifdef MISALIGN_CHECK_EN
            mis_q   <= mis_d;
`endif
        end
    end

    assign res_valid_out  = valid_q;
    assign res_data_out   = data_q;
    assign res_rob_ix_out = rob_q;
`ifdef MISALIGN_CHECK_EN
    assign res_misalign_out = mis_q;
`endif

endmodule

// File: tb/tb_load_unit.sv
// Bench for load_unit: BRAM model with fixed read latency, directed cases,
// then randomized loads checked against an arithmetic reference model.
module tb_load_unit;

    localparam int unsigned ROB_IX      = 2;
    localparam int unsigned ADDR_W      = 10;
    localparam int unsigned MEM_LATENCY = 2;

    logic              clk_in = 1'b0;
    logic              rst_in;
    logic              flush_in;
    logic              lb_valid_in;
    logic [31:0]       lb_addr_in;
    logic [ROB_IX:0]   lb_rob_ix_in;
    logic [2:0]        lb_funct3_in;
    logic              read_out;
    logic              mem_en_out;
    logic [ADDR_W-1:0] mem_addr_out;
    logic [31:0]       mem_rdata_in;
    logic              res_valid_out;
    logic              res_ready_in;
    logic [31:0]       res_data_out;
    logic [ROB_IX:0]   res_rob_ix_out;
`ifdef MISALIGN_CHECK_EN
    logic              res_misalign_out;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem  [0:(1<<ADDR_W)-1];
    logic [31:0] pipe [0:MEM_LATENCY-1];

    load_unit #(.ROB_IX(ROB_IX), .ADDR_W(ADDR_W), .MEM_LATENCY(MEM_LATENCY)) dut (
        .clk_in        (clk_in),
        .rst_in        (rst_in),
        .flush_in      (flush_in),
        .lb_valid_in   (lb_valid_in),
        .lb_addr_in    (lb_addr_in),
        .lb_rob_ix_in  (lb_rob_ix_in),
        .lb_funct3_in  (lb_funct3_in),
        .read_out      (read_out),
        .mem_en_out    (mem_en_out),
        .mem_addr_out  (mem_addr_out),
        .mem_rdata_in  (mem_rdata_in),
        .res_valid_out (res_valid_out),
        .res_ready_in  (res_ready_in),
        .res_data_out  (res_data_out),
`ifdef MISALIGN_CHECK_EN
        .res_misalign_out (res_misalign_out),
`endif
        .res_rob_ix_out(res_rob_ix_out)
    );

    always #5 clk_in = ~clk_in;

    // BRAM model: data for an enabled read appears MEM_LATENCY cycles later; junk otherwise.
    always @(posedge clk_in) begin
        pipe[0] <= mem_en_out ? mem[mem_addr_out] : $urandom;
        for (int i = 1; i < MEM_LATENCY; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata_in = pipe[MEM_LATENCY-1];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: pick the byte/halfword arithmetically and extend by adding the sign fill.
    function automatic logic [31:0] fmt_ref(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [1:0] off);
        longint unsigned v;
        v = w;
        if (f3 == 3'd0 || f3 == 3'd4) begin
            v = (v >> (8 * int'(off))) % 256;
            if (f3 == 3'd0 && v >= 128) v = v + 64'hFFFF_FF00;
        end else if (f3 == 3'd1 || f3 == 3'd5) begin
            v = (v >> (16 * (int'(off) / 2))) % 65536;
            if (f3 == 3'd1 && v >= 32768) v = v + 64'hFFFF_0000;
        end
        return 32'(v);
    endfunction

    function automatic logic mis_ref(input logic [2:0] f3, input logic [1:0] off);
        if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
        if (f3 == 3'd1 || f3 == 3'd5) return (int'(off) % 2) == 1;
        return off != 2'd0;
    endfunction

    // Issue one load from an idle DUT (called at a negedge), check latency, result, stall and handshake.
    task automatic do_load(input logic [31:0] addr, input logic [ROB_IX:0] rob,
                           input logic [2:0] f3, input int stall);
        logic [31:0] exp;
        int lat;
        exp = fmt_ref(mem[addr[ADDR_W+1:2]], f3, addr[1:0]);
        lb_valid_in  = 1'b1;
        lb_addr_in   = addr;
        lb_rob_ix_in = rob;
        lb_funct3_in = f3;
        res_ready_in = (stall == 0);
        #1;
        check("accept_read", 32'(read_out), 32'd1);
        check("accept_mem_en", 32'(mem_en_out), 32'd1);
        check("accept_mem_addr", 32'(mem_addr_out), 32'(addr[ADDR_W+1:2]));
        check("accept_no_valid", 32'(res_valid_out), 32'd0);
        @(negedge clk_in);
        lb_valid_in  = 1'b0;
        lb_addr_in   = $urandom;
        lb_funct3_in = 3'($urandom);
        lb_rob_ix_in = (ROB_IX+1)'($urandom);
        lat = 1;
        while (!res_valid_out && lat < 20) begin
            @(negedge clk_in);
            lat++;
        end
        check("latency", 32'(lat), 32'(MEM_LATENCY + 1));
        check("res_data", res_data_out, exp);
        check("res_rob", 32'(res_rob_ix_out), 32'(rob));
`ifdef MISALIGN_CHECK_EN
        check("res_misalign", 32'(res_misalign_out), 32'(mis_ref(f3, addr[1:0])));
`endif
        for (int i = 0; i < stall; i++) begin
            lb_valid_in = 1'b1;
            #1;
            check("stall_read_blocked", 32'(read_out), 32'd0);
            check("stall_valid", 32'(res_valid_out), 32'd1);
            check("stall_data", res_data_out, exp);
            check("stall_rob", 32'(res_rob_ix_out), 32'(rob));
            @(negedge clk_in);
        end
        lb_valid_in  = 1'b0;
        res_ready_in = 1'b1;
        @(negedge clk_in);
        res_ready_in = 1'b0;
        check("post_handshake_valid", 32'(res_valid_out), 32'd0);
    endtask

    logic [2:0] f3_pool [0:7] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

    initial begin
        logic [31:0] a;
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = $urandom;
        rst_in       = 1'b1;
        flush_in     = 1'b0;
        lb_valid_in  = 1'b1;
        lb_addr_in   = '0;
        lb_rob_ix_in = '0;
        lb_funct3_in = '0;
        res_ready_in = 1'b0;
        #1 rst_in = 1'b0;
        @(negedge clk_in);
        @(negedge clk_in);
        check("rst_valid", 32'(res_valid_out), 32'd0);
        check("rst_data", res_data_out, 32'd0);
        check("rst_rob", 32'(res_rob_ix_out), 32'd0);
        check("rst_read", 32'(read_out), 32'd0);
        check("rst_mem_en", 32'(mem_en_out), 32'd0);
        rst_in      = 1'b1;
        lb_valid_in = 1'b0;
        @(negedge clk_in);

        // Basic word load.
        mem[4] = 32'hDEAD_BEEF;
        do_load(32'h0000_0010, 3'd3, 3'b010, 0);

        // Sub-word extraction and extension.
        mem[10'h40] = 32'h80F1_7F82;
        do_load(32'h0000_0100, 3'd1, 3'b000, 0);
        do_load(32'h0000_0100, 3'd2, 3'b100, 0);
        do_load(32'h0000_0101, 3'd4, 3'b000, 0);
        do_load(32'h0000_0102, 3'd5, 3'b001, 0);
        do_load(32'h0000_0102, 3'd6, 3'b101, 0);
        check("ref_lb0", fmt_ref(32'h80F1_7F82, 3'd0, 2'd0), 32'hFFFF_FF82);

        // Backpressure for five cycles, then a back-to-back load.
        do_load(32'h0000_0204, 3'd7, 3'b010, 5);
        do_load(32'h0000_0208, 3'd0, 3'b001, 0);

        // Misalignment cases (data still formatted normally).
        do_load(32'h0000_0302, 3'd2, 3'b010, 0);
        do_load(32'h0000_0302, 3'd3, 3'b001, 0);
        do_load(32'h0000_0303, 3'd4, 3'b000, 0);

        // Flush in WAIT, then a fresh load two cycles later.
        mem[10'h11] = 32'h1234_5678;
        lb_valid_in = 1'b1; lb_addr_in = 32'h0000_0020; lb_rob_ix_in = 3'd5; lb_funct3_in = 3'b010;
        #1 check("flush_setup_read", 32'(read_out), 32'd1);
        @(negedge clk_in);
        flush_in = 1'b1;
        #1;
        check("flush_read_blocked", 32'(read_out), 32'd0);
        check("flush_mem_en", 32'(mem_en_out), 32'd0);
        @(negedge clk_in);
        flush_in = 1'b0; lb_valid_in = 1'b0;
        check("flush_no_valid1", 32'(res_valid_out), 32'd0);
        @(negedge clk_in);
        check("flush_no_valid2", 32'(res_valid_out), 32'd0);
        do_load(32'h0000_0044, 3'd6, 3'b010, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            check("flush_no_extra", 32'(res_valid_out), 32'd0);
        end

        // Reset in the middle of WAIT.
        lb_valid_in = 1'b1; lb_addr_in = 32'h0000_0050; lb_rob_ix_in = 3'd2; lb_funct3_in = 3'b010;
        #1 check("rstmid_setup_read", 32'(read_out), 32'd1);
        @(negedge clk_in);
        rst_in = 1'b0;
        #1;
        check("rstmid_valid", 32'(res_valid_out), 32'd0);
        check("rstmid_read", 32'(read_out), 32'd0);
        check("rstmid_mem_en", 32'(mem_en_out), 32'd0);
        @(negedge clk_in);
        rst_in = 1'b1; lb_valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_in);
            check("rstmid_no_result", 32'(res_valid_out), 32'd0);
        end

        // Randomized loads.
        for (int n = 0; n < 60; n++) begin
            a = $urandom;
            mem[a[ADDR_W+1:2]] = $urandom;
            do_load(a, (ROB_IX+1)'($urandom), f3_pool[$urandom_range(0, 7)],
                    int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/load_unit.md
Name: load_unit

Overview:
Memory-access stage directly downstream of the load buffer. It accepts one issued load (address, ROB index, funct3), performs a fixed-latency read from the data BRAM, then aligns and sign/zero-extends the returned word. The result is held on a valid/ready result port until the ROB/CDB arbiter accepts it. One load is in flight at a time; flush squashes it.

Parameters:
ROB_IX, 2, MSB index of the ROB tag; the tag width is ROB_IX+1.
ADDR_W, 10, BRAM word-address width.
MEM_LATENCY, 2, BRAM read latency in cycles from mem_en_out to valid mem_rdata_in; must be at least 1.

Ports:
clk_in  input  1  clock
rst_in  input  1  asynchronous active-low reset
flush_in  input  1  squash the in-flight load; synchronous
lb_valid_in  input  1  load buffer has a load ready
lb_addr_in  input  32  byte address from the load buffer
lb_rob_ix_in  input  ROB_IX+1  ROB tag of the load
lb_funct3_in  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
read_out  output  1  accept strobe to the load buffer (drives its read_in)
mem_en_out  output  1  BRAM read enable
mem_addr_out  output  ADDR_W  BRAM word address
mem_rdata_in  input  32  BRAM read data
res_valid_out  output  1  result is valid
res_ready_in  input  1  ROB/CDB accepts the result
res_data_out  output  32  extended load data
res_rob_ix_out  output  ROB_IX+1  ROB tag of the result

Behaviour:
- States: IDLE, WAIT, RESP. Reset, asserted asynchronously while rst_in=0: state=IDLE, counter=0, every registered output 0.
- read_out is combinational: read_out = (state==IDLE) && lb_valid_in && !flush_in. A request is accepted on any rising clock edge where read_out=1.
- On accept:
  - Latch lb_addr_in[1:0], lb_funct3_in and lb_rob_ix_in.
  - Assert mem_en_out for exactly that cycle, combinationally with read_out.
  - mem_addr_out = lb_addr_in[ADDR_W+1:2]; the upper address bits are ignored.
  - Set counter = MEM_LATENCY-1 and go to WAIT.
- WAIT: decrement the counter each cycle. In the cycle where counter==0, capture mem_rdata_in, format it, and go to RESP. Accept-to-res_valid_out latency is MEM_LATENCY+1 cycles.
- Formatting uses the latched byte offset off = addr[1:0]:
  - LB/LBU: byte at [8*off+7:8*off], sign- or zero-extended.
  - LH/LHU: halfword at [16*off[1]+15:16*off[1]]; off[0] is ignored.
  - LW: the full word; off is ignored.
  - Any other funct3: treated as LW.
- RESP:
  - res_valid_out=1; res_data_out and res_rob_ix_out are stable until the handshake.
  - Handshake is res_valid_out && res_ready_in. The result is consumed at that edge; next state is IDLE and res_valid_out drops.
  - No new accept in the same cycle as the handshake, because read_out requires IDLE. Back-to-back throughput is therefore one load per MEM_LATENCY+2 cycles.
- flush_in=1 in any state: next state IDLE, counter=0, res_valid_out=0 the next cycle, read_out=0 this cycle. A BRAM response still in flight is ignored; a fresh load is timed from its own accept.
- Flush takes priority over the result handshake. A RESP cycle with flush_in=1 and res_ready_in=1 still drops the result.
- mem_en_out=0 whenever no accept is occurring.
- Reset mid-operation: immediate return to IDLE with outputs cleared; no result is emitted.

Optional Feature:
Macro MISALIGN_CHECK_EN.
- When defined:
  - Extra output res_misalign_out (1 bit), registered alongside res_valid_out.
  - It is set when an LH/LHU has off[0]=1, or an LW has off!=0.
  - The data path is unchanged; the flag travels with the result and is cleared on reset, flush and handshake.
- When undefined: the port does not exist and misaligned loads are silently formatted as described above.

Test Plan:
1. Reset with rst_in=0 mid-WAIT -> state IDLE immediately; res_valid_out=0, read_out=0, mem_en_out=0 while in reset.
2. LW addr=0x0000_0010, rob=3, MEM_LATENCY=2, rdata=0xDEADBEEF, res_ready_in=1 -> mem_addr_out=4 on the accept cycle; res_valid_out high 3 cycles later with data 0xDEADBEEF, rob 3.
3. rdata=0x80F1_7F82:
   - LB off=0 -> 0xFFFFFF82.
   - LBU off=0 -> 0x00000082.
   - LB off=1 -> 0x0000007F.
   - LH off=2 -> 0xFFFF80F1.
   - LHU off=2 -> 0x000080F1.
4. Backpressure: hold res_ready_in=0 for 5 cycles in RESP -> data and rob stable, read_out=0 despite lb_valid_in=1; raise ready -> handshake, IDLE next cycle, the following load is accepted.
5. Flush during WAIT (counter=1), then a new LW 2 cycles later with rdata 0x12345678 -> no result for the squashed load; exactly one result 0x12345678 with the new rob tag.
6. With MISALIGN_CHECK_EN: LW addr=0x...2 -> res_misalign_out=1; LH addr=0x...2 -> 0; LB addr=0x...3 -> 0.
